// File: rtl/alu_pkg.sv
// Shared types for the integer ALU: opcode encoding and the status flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SLL  = 4'b0000,
        OP_SRL  = 4'b0001,
        OP_SRA  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_NOT  = 4'b1000,
        OP_ROL  = 4'b1001,
        OP_ROR  = 4'b1010,
        OP_PASS = 4'b1011,
        OP_SLT  = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic negative;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the issue logic (master) and the ALU (slave).
interface alu_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             overflow;
    logic             negative;
    logic             zero;

    modport master (
        output opcode, a, b, cin,
        input  y, cout, overflow, negative, zero
    );

    modport slave (
        input  opcode, a, b, cin,
        output y, cout, overflow, negative, zero
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit; also reports the last bit shifted out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             cout
);
    localparam logic [WIDTH:0]   W_X = (WIDTH+1)'(WIDTH);
    localparam logic [WIDTH-1:0] W_B = WIDTH'(WIDTH);

    logic [WIDTH:0]   sh_x;
    logic [WIDTH:0]   left_x;
    logic [WIDTH:0]   right_x;
    logic [WIDTH-1:0] rot;

    // One guard bit on each side catches the last bit out for in-range amounts.
    assign sh_x    = {1'b0, b};
    assign left_x  = {1'b0, a} << b;
    assign right_x = {a, 1'b0} >> b;
    assign rot     = b % W_B;

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_SLL: begin
                y = a << b;
                if (sh_x == W_X)     cout = a[WIDTH-1];
                else if (sh_x < W_X) cout = left_x[WIDTH];
            end
            OP_SRL: begin
                y = a >> b;
                if (sh_x < W_X) cout = right_x[0];
            end
            OP_SRA: begin
                y = WIDTH'($signed(a) >>> b);
                if (sh_x <= W_X) cout = right_x[0];
            end
            OP_ROL:  y = (a << rot) | (a >> (W_B - rot));
            OP_ROR:  y = (a >> rot) | (a << (W_B - rot));
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_core.sv
// Execute-stage integer ALU: decodes the opcode and registers result plus flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sy);
        return (sa == sb) && (sy != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sy);
        return (sa != sb) && (sy != sa);
    endfunction

    alu_op_e                 op;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [WIDTH:0]   sum_x;
    logic        [WIDTH:0]   diff_x;
    logic        [WIDTH-1:0] sh_y;
    logic                    sh_cout;
    logic        [WIDTH-1:0] y_p0;
    alu_flags_t              flags_p0;
    logic        [WIDTH-1:0] y_p1;
    alu_flags_t              flags_p1;

    assign op  = alu_op_e'(bus.opcode);
    assign a_s = $signed(bus.a);
    assign b_s = $signed(bus.b);

    // Extra top bit carries out of ADD and goes high on SUB borrow.
    assign sum_x  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    assign diff_x = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .op   (op),
        .a    (bus.a),
        .b    (bus.b),
        .y    (sh_y),
        .cout (sh_cout)
    );

    always_comb begin
        y_p0     = '0;
        flags_p0 = '0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: begin
                y_p0          = sh_y;
                flags_p0.cout = sh_cout;
            end
            OP_ROL, OP_ROR: y_p0 = sh_y;
            OP_ADD: begin
                y_p0              = sum_x[WIDTH-1:0];
                flags_p0.cout     = sum_x[WIDTH];
                flags_p0.overflow = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum_x[WIDTH-1]);
            end
            OP_SUB: begin
                y_p0              = diff_x[WIDTH-1:0];
                flags_p0.cout     = diff_x[WIDTH];
                flags_p0.overflow = sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], diff_x[WIDTH-1]);
            end
            OP_AND:  y_p0 = bus.a & bus.b;
            OP_OR:   y_p0 = bus.a | bus.b;
            OP_XOR:  y_p0 = bus.a ^ bus.b;
            OP_NOT:  y_p0 = ~bus.a;
            OP_PASS: y_p0 = bus.b;
            OP_SLT:  y_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: ;
        endcase
        flags_p0.negative = y_p0[WIDTH-1];
        flags_p0.zero     = (y_p0 == '0);
    end

    // p0 -> p1: result and flags captured together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1     <= '0;
            flags_p1 <= '{cout: 1'b0, overflow: 1'b0, negative: 1'b0, zero: 1'b1};
        end else begin
            y_p1     <= y_p0;
            flags_p1 <= flags_p0;
        end
    end

    assign bus.y        = y_p1;
    assign bus.cout     = flags_p1.cout;
    assign bus.overflow = flags_p1.overflow;
    assign bus.negative = flags_p1.negative;
    assign bus.zero     = flags_p1.zero;
endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core at WIDTH=4 with hand-computed expectations.
module tb_alu_core;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_if #(.WIDTH(4)) bus ();

    alu_core #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.cout, bus.overflow, bus.negative, bus.zero};
    endfunction

    // flags packed as {cout, overflow, negative, zero}
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic cin,
                           input logic [3:0] exp_y, input logic [3:0] exp_f);
        @(negedge clk);
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        @(posedge clk);
        #1;
        check({tag, ".y"}, 32'(bus.y), 32'(exp_y));
        check({tag, ".flags"}, 32'(flags_now()), 32'(exp_f));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        bus.opcode = 4'b0011;
        bus.a      = 4'b0101;
        bus.b      = 4'b0110;
        bus.cin    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset.y", 32'(bus.y), 32'h0);
        check("reset.flags", 32'(flags_now()), 32'b0001);
        @(posedge clk);
        #1;
        check("reset_hold.y", 32'(bus.y), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("sll1",      4'b0000, 4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0000);
        run_vec("srl1",      4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b1001);
        run_vec("sra1",      4'b0010, 4'b1001, 4'b0001, 1'b0, 4'b1100, 4'b1010);
        run_vec("sra7",      4'b0010, 4'b1000, 4'b0111, 1'b0, 4'b1111, 4'b0010);
        run_vec("sll4",      4'b0000, 4'b1111, 4'b0100, 1'b0, 4'b0000, 4'b1001);
        run_vec("sll0",      4'b0000, 4'b1011, 4'b0000, 1'b0, 4'b1011, 4'b0010);
        run_vec("srl4",      4'b0001, 4'b1000, 4'b0100, 1'b0, 4'b0000, 4'b0001);
        run_vec("sra4",      4'b0010, 4'b1010, 4'b0100, 1'b0, 4'b1111, 4'b1010);
        run_vec("sll2",      4'b0000, 4'b0110, 4'b0010, 1'b0, 4'b1000, 4'b1010);
        run_vec("add_ovf",   4'b0011, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0110);
        run_vec("add_carry", 4'b0011, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b1001);
        run_vec("add_cin",   4'b0011, 4'b0010, 4'b0011, 1'b1, 4'b0110, 4'b0000);
        run_vec("sub_brw",   4'b0100, 4'b0000, 4'b0001, 1'b0, 4'b1111, 4'b1010);
        run_vec("sub_ovf",   4'b0100, 4'b1000, 4'b0001, 1'b0, 4'b0111, 4'b0100);
        run_vec("sub_cin",   4'b0100, 4'b0101, 4'b0011, 1'b1, 4'b0001, 4'b0000);
        run_vec("and",       4'b0101, 4'b1100, 4'b1010, 1'b0, 4'b1000, 4'b0010);
        run_vec("or",        4'b0110, 4'b1100, 4'b1010, 1'b0, 4'b1110, 4'b0010);
        run_vec("xor",       4'b0111, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b0000);
        run_vec("not",       4'b1000, 4'b1100, 4'b1010, 1'b1, 4'b0011, 4'b0000);
        run_vec("rol1",      4'b1001, 4'b1001, 4'b0001, 1'b0, 4'b0011, 4'b0000);
        run_vec("ror1",      4'b1010, 4'b1001, 4'b0001, 1'b0, 4'b1100, 4'b0010);
        run_vec("rol5",      4'b1001, 4'b1001, 4'b0101, 1'b0, 4'b0011, 4'b0000);
        run_vec("ror6",      4'b1010, 4'b0001, 4'b0110, 1'b0, 4'b0100, 4'b0000);
        run_vec("passb",     4'b1011, 4'b0101, 4'b1010, 1'b1, 4'b1010, 4'b0010);
        run_vec("slt_t",     4'b1100, 4'b1000, 4'b0001, 1'b0, 4'b0001, 4'b0000);
        run_vec("slt_f",     4'b1100, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0001);
        run_vec("slt_eq",    4'b1100, 4'b0011, 4'b0011, 1'b0, 4'b0000, 4'b0001);
        run_vec("rsvd",      4'b1101, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0001);
        run_vec("rsvd_f",    4'b1111, 4'b0111, 4'b0001, 1'b1, 4'b0000, 4'b0001);

        // Operands change between edges; result must wait for the next rising edge.
        run_vec("lat_pre",   4'b0011, 4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0000);
        @(negedge clk);
        bus.opcode = 4'b0011;
        bus.a      = 4'b0100;
        bus.b      = 4'b0001;
        bus.cin    = 1'b0;
        #2;
        check("lat_hold.y", 32'(bus.y), 32'h2);
        @(posedge clk);
        #1;
        check("lat_upd.y", 32'(bus.y), 32'h5);

        // Asynchronous clear mid-run, away from any clock edge.
        run_vec("pre_rst",   4'b1011, 4'b0000, 4'b1001, 1'b0, 4'b1001, 4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.y", 32'(bus.y), 32'h0);
        check("midrst.flags", 32'(flags_now()), 32'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst",  4'b0011, 4'b0011, 4'b0100, 1'b0, 4'b0111, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
